// File: rtl/aether_mem_pkg.sv
// Shared memory-stage command encodings, controller FSM states and the task descriptor.
package aether_mem_pkg;

    localparam logic [1:0] MEM_IDLE  = 2'b00;
    localparam logic [1:0] MEM_WRITE = 2'b01;
    localparam logic [1:0] MEM_READ  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ISSUE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    typedef struct packed {
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } mem_task_t;

endpackage

// File: rtl/aether_mem_read_fifo.sv
// Read-data FIFO: buffers memory read words for the engine, exposes head and free count.
// Latency: a pushed word is visible at the head one cycle later.
// Backpressure: pop_rdy only drains; a push at full lands only alongside a pop.
module aether_mem_read_fifo #(
    parameter int Depth = 128,
    parameter int Width = 16,
    parameter int CntW  = $clog2(Depth) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_vld,
    input  logic [Width-1:0] push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [Width-1:0] pop_dat,
    output logic [CntW-1:0]  free_cnt
);

    localparam int AddrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q;
    logic [AddrW-1:0] rd_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             full;
    logic             pop;
    logic             push;

    assign full     = (cnt_q == CntW'(Depth));
    assign pop_vld  = (cnt_q != '0);
    assign pop      = pop_vld && pop_rdy;
    // At full the slot being popped this cycle is the one written.
    assign push     = push_vld && (!full || pop);
    assign pop_dat  = mem_q[rd_ptr_q];
    assign free_cnt = CntW'(Depth) - cnt_q;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AddrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AddrW'(1);
            end
            cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
        end
    end

`ifdef ENABLE_SIMULATION_ASSERTS
    logic assert_on;
    assign assert_on = 1'b1;

    push_when_full: assert property (@(posedge clk_i) disable iff (rst_i || !assert_on)
        !(push_vld && full && !pop));
`endif

endmodule

// File: rtl/aether_mem_transfer_ctrl.sv
// Splits engine block transfers into memory tasks of at most ChunkWords words and streams data.
// Latency: request to ISSUE in 2 cycles; len==0 or rejected requests pulse done_o 2 cycles after accept.
// Backpressure: write words move only on wr_valid_i && memory ready; reads issue only when the FIFO can hold the whole chunk.
module aether_mem_transfer_ctrl
    import aether_mem_pkg::*;
#(
    parameter int ChunkWords = 64,
    parameter int FifoDepth  = 128,
    parameter int LenBits    = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_write_i,
    input  logic [31:0]        req_start_i,
    input  logic [LenBits-1:0] req_len_i,
    output logic               done_o,
    output logic               error_o,
    input  logic [15:0]        wr_data_i,
    input  logic               wr_valid_i,
    output logic               wr_ready_o,
    output logic [15:0]        rd_data_o,
    output logic               rd_valid_o,
    input  logic               rd_ready_i,
    output logic [1:0]         mem_command_o,
    output logic [31:0]        mem_start_address_o,
    output logic [31:0]        mem_end_address_o,
    output logic               mem_en_o,
    output logic [15:0]        mem_data_write_o,
    input  logic [15:0]        mem_data_read_i,
    input  logic               mem_data_read_valid_i,
    input  logic               mem_data_write_ready_i,
    input  logic               mem_task_finished_i,
    input  logic               mem_running_i
);

    localparam int CntW = $clog2(FifoDepth) + 1;

    state_e             state_q;
    state_e             state_d;
    logic               err_q;
    logic               err_d;
    logic               is_write_q;
    logic [31:0]        cur_addr_q;
    logic [LenBits-1:0] remaining_q;
    mem_task_t          task_q;
    logic               drain_seen_q;

    logic [LenBits-1:0] chunk;
    logic [31:0]        chunk_end;
    logic               len_zero;
    logic               addr_ovf;
    logic               end_zero;
    logic               fifo_fits;
    logic [CntW-1:0]    fifo_free;
    logic               fifo_push;
    logic               wr_fire;
    logic               drain_quiet;

    assign chunk       = (remaining_q < LenBits'(ChunkWords)) ? remaining_q : LenBits'(ChunkWords);
    assign chunk_end   = cur_addr_q + 32'(chunk) - 32'd1;
    assign len_zero    = (remaining_q == '0);
    // start + len - 1 wraps exactly when len - 1 exceeds the headroom above start.
    assign addr_ovf    = (32'(remaining_q) - 32'd1) > ~cur_addr_q;
    // The memory never completes a task whose end address is 0.
    assign end_zero    = (chunk_end == 32'd0);
    assign fifo_fits   = (32'(fifo_free) >= 32'(chunk));
    assign drain_quiet = !mem_running_i && !mem_task_finished_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_d = CHECK;
                    err_d   = 1'b0;
                end
            end
            CHECK: begin
                if (len_zero) begin
                    state_d = DONE;
                    err_d   = 1'b0;
                end else if (addr_ovf || end_zero) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else if (is_write_q || fifo_fits) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = RUN;
            RUN: begin
                if (mem_task_finished_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_seen_q) begin
                    state_d = (remaining_q == chunk) ? DONE : CHECK;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o   = (state_q == IDLE);
        done_o        = (state_q == DONE);
        error_o       = (state_q == DONE) && err_q;
        mem_command_o = MEM_IDLE;
        if (state_q == ISSUE) begin
            mem_command_o = is_write_q ? MEM_WRITE : MEM_READ;
        end
        wr_fire   = (state_q == RUN) && is_write_q && wr_valid_i && mem_data_write_ready_i;
        fifo_push = (state_q == RUN) && !is_write_q && mem_data_read_valid_i;
    end

    assign wr_ready_o          = wr_fire;
    assign mem_en_o            = wr_fire;
    assign mem_data_write_o    = wr_data_i;
    assign mem_start_address_o = task_q.start_addr;
    assign mem_end_address_o   = task_q.end_addr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q        <= 1'b0;
            is_write_q   <= 1'b0;
            cur_addr_q   <= '0;
            remaining_q  <= '0;
            task_q       <= '0;
            drain_seen_q <= 1'b0;
        end else begin
            err_q <= err_d;
            if (state_q == IDLE && req_valid_i) begin
                is_write_q  <= req_write_i;
                cur_addr_q  <= req_start_i;
                remaining_q <= req_len_i;
            end
            if (state_q == CHECK && state_d == ISSUE) begin
                task_q <= '{start_addr: cur_addr_q, end_addr: chunk_end};
            end
            // Memory must be quiet for a full cycle before the next chunk is considered.
            drain_seen_q <= (state_q == DRAIN) && !drain_seen_q && drain_quiet;
            if (state_q == DRAIN && drain_seen_q) begin
                cur_addr_q  <= cur_addr_q + 32'(chunk);
                remaining_q <= remaining_q - chunk;
            end
        end
    end

    aether_mem_read_fifo #(
        .Depth (FifoDepth),
        .Width (16),
        .CntW  (CntW)
    ) u_read_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_vld (fifo_push),
        .push_dat (mem_data_read_i),
        .pop_vld  (rd_valid_o),
        .pop_rdy  (rd_ready_i),
        .pop_dat  (rd_data_o),
        .free_cnt (fifo_free)
    );

endmodule

// File: tb/tb_aether_mem_transfer_ctrl.sv
// Directed bench for aether_mem_transfer_ctrl with a behavioural memory stage and read consumer.
module tb_aether_mem_transfer_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_write_i = 1'b0;
    logic [31:0] req_start_i = '0;
    logic [15:0] req_len_i = '0;
    logic        done_o;
    logic        error_o;
    logic [15:0] wr_data_i = 16'hC000;
    logic        wr_valid_i = 1'b0;
    logic        wr_ready_o;
    logic [15:0] rd_data_o;
    logic        rd_valid_o;
    logic        rd_ready_i = 1'b0;
    logic [1:0]  mem_command_o;
    logic [31:0] mem_start_address_o;
    logic [31:0] mem_end_address_o;
    logic        mem_en_o;
    logic [15:0] mem_data_write_o;
    logic [15:0] mem_data_read_i = '0;
    logic        mem_data_read_valid_i = 1'b0;
    logic        mem_data_write_ready_i = 1'b0;
    logic        mem_task_finished_i = 1'b0;
    logic        mem_running_i = 1'b0;

    int checks = 0;
    int passes = 0;

    aether_mem_transfer_ctrl #(.ChunkWords(64), .FifoDepth(128), .LenBits(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_start_i(req_start_i), .req_len_i(req_len_i),
        .done_o(done_o), .error_o(error_o),
        .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
        .mem_command_o(mem_command_o), .mem_start_address_o(mem_start_address_o),
        .mem_end_address_o(mem_end_address_o), .mem_en_o(mem_en_o),
        .mem_data_write_o(mem_data_write_o), .mem_data_read_i(mem_data_read_i),
        .mem_data_read_valid_i(mem_data_read_valid_i),
        .mem_data_write_ready_i(mem_data_write_ready_i),
        .mem_task_finished_i(mem_task_finished_i), .mem_running_i(mem_running_i)
    );

    always #5 clk_i = ~clk_i;

    // Memory stage model and logs, evaluated on the falling edge.
    int          m_state = 0;
    logic [31:0] m_cur = '0;
    int          m_left = 0;
    bit          m_write = 1'b0;
    bit          m_post_rst = 1'b0;
    int          wr_cnt = 0;
    logic [1:0]  task_cmd_q[$];
    logic [31:0] task_start_q[$];
    logic [31:0] task_end_q[$];
    logic [15:0] wr_words_q[$];
    logic [15:0] rx_q[$];

    function automatic logic [15:0] exp_rd(input logic [31:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    always @(negedge clk_i) begin
        if (rst_i) begin
            m_state = 0;
            mem_running_i = 1'b0;
            mem_task_finished_i = 1'b0;
            mem_data_read_valid_i = 1'b0;
            mem_data_write_ready_i = 1'b0;
            m_post_rst = 1'b1;
        end else begin
            mem_task_finished_i = 1'b0;
            mem_data_read_valid_i = 1'b0;
            if (rd_valid_o && rd_ready_i) rx_q.push_back(rd_data_o);
            if (m_post_rst) begin
                // The memory stage raises task_finished once after its own reset.
                m_post_rst = 1'b0;
                mem_task_finished_i = 1'b1;
            end else begin
                case (m_state)
                    0: if (mem_command_o != 2'b00) begin
                        task_cmd_q.push_back(mem_command_o);
                        task_start_q.push_back(mem_start_address_o);
                        task_end_q.push_back(mem_end_address_o);
                        m_write = (mem_command_o == 2'b01);
                        m_cur = mem_start_address_o;
                        m_left = int'(mem_end_address_o - mem_start_address_o) + 1;
                        mem_running_i = 1'b1;
                        mem_data_write_ready_i = m_write;
                        m_state = 1;
                    end
                    1: if (m_left == 0) begin
                        mem_task_finished_i = 1'b1;
                        mem_data_write_ready_i = 1'b0;
                        m_state = 2;
                    end else if (m_write) begin
                        if (mem_en_o) begin
                            wr_words_q.push_back(mem_data_write_o);
                            m_cur = m_cur + 1;
                            m_left = m_left - 1;
                            wr_cnt = wr_cnt + 1;
                        end
                    end else begin
                        mem_data_read_valid_i = 1'b1;
                        mem_data_read_i = exp_rd(m_cur);
                        m_cur = m_cur + 1;
                        m_left = m_left - 1;
                    end
                    default: begin
                        mem_running_i = 1'b0;
                        m_state = 0;
                    end
                endcase
            end
        end
    end

    // Write source: a new word appears after each consumed one.
    always @(posedge clk_i) begin
        #1;
        wr_data_i = 16'hC000 + 16'(wr_cnt);
    end

    task automatic send_req(input bit wr, input logic [31:0] start, input logic [15:0] len);
        @(posedge clk_i); #1;
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_start_i = start;
        req_len_i   = len;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got, output logic err, output int cyc);
        got = 1'b0; err = 1'b0; cyc = 0;
        while (!got && cyc < budget) begin
            @(negedge clk_i);
            cyc++;
            if (done_o === 1'b1) begin
                got = 1'b1;
                err = error_o;
            end
        end
    endtask

    task automatic test_reset();
        wr_valid_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if (req_ready_o !== 1'b1) $display("FAIL reset_req_ready got %b want 1", req_ready_o); else passes++;
        checks++; if ({done_o, error_o, wr_ready_o, mem_en_o} !== 4'b0000)
            $display("FAIL reset_ctrl_outs got %b want 0000", {done_o, error_o, wr_ready_o, mem_en_o}); else passes++;
        checks++; if (rd_valid_o !== 1'b0) $display("FAIL reset_rd_valid got %b want 0", rd_valid_o); else passes++;
        checks++; if ({mem_command_o, mem_start_address_o, mem_end_address_o} !== 66'd0)
            $display("FAIL reset_mem_outs got %h/%h/%h want 0", mem_command_o, mem_start_address_o, mem_end_address_o); else passes++;
        wr_valid_i = 1'b0;
        rst_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        checks++; if (req_ready_o !== 1'b1) $display("FAIL post_reset_finished_ignored got %b want 1", req_ready_o); else passes++;
    endtask

    task automatic test_write();
        int tb0 = task_cmd_q.size();
        int wb0 = wr_words_q.size();
        int base = wr_cnt;
        int cyc; bit got; logic err;
        wr_valid_i = 1'b1;
        send_req(1'b1, 32'h10, 16'd5);
        wait_done(200, got, err, cyc);
        wr_valid_i = 1'b0;
        checks++; if (got !== 1'b1 || err !== 1'b0) $display("FAIL wr_done got done=%b err=%b want 1/0", got, err); else passes++;
        checks++; if (task_cmd_q.size() - tb0 !== 1) $display("FAIL wr_task_count got %0d want 1", task_cmd_q.size() - tb0); else passes++;
        if (task_cmd_q.size() > tb0) begin
            checks++; if ({task_cmd_q[tb0], task_start_q[tb0], task_end_q[tb0]} !== {2'b01, 32'h10, 32'h14})
                $display("FAIL wr_task got %h %h %h want 1 10 14", task_cmd_q[tb0], task_start_q[tb0], task_end_q[tb0]); else passes++;
        end
        checks++; if (wr_words_q.size() - wb0 !== 5) $display("FAIL wr_handshakes got %0d want 5", wr_words_q.size() - wb0); else passes++;
        for (int i = 0; i < 5 && wb0 + i < wr_words_q.size(); i++) begin
            checks++; if (wr_words_q[wb0 + i] !== 16'hC000 + 16'(base + i))
                $display("FAIL wr_data[%0d] got %h want %h", i, wr_words_q[wb0 + i], 16'hC000 + 16'(base + i)); else passes++;
        end
        checks++; if ({mem_start_address_o, mem_end_address_o} !== {32'h10, 32'h14})
            $display("FAIL wr_addr_hold got %h %h want 10 14", mem_start_address_o, mem_end_address_o); else passes++;
    endtask

    task automatic test_read_chunks();
        logic [31:0] exp_s [3] = '{32'h100, 32'h140, 32'h180};
        logic [31:0] exp_e [3] = '{32'h13F, 32'h17F, 32'h195};
        int tb0 = task_cmd_q.size();
        int rb0 = rx_q.size();
        int cyc; bit got; logic err; int bad;
        rd_ready_i = 1'b1;
        send_req(1'b0, 32'h100, 16'd150);
        wait_done(2000, got, err, cyc);
        repeat (5) @(posedge clk_i);
        checks++; if (got !== 1'b1 || err !== 1'b0) $display("FAIL rd_done got done=%b err=%b want 1/0", got, err); else passes++;
        checks++; if (task_cmd_q.size() - tb0 !== 3) $display("FAIL rd_task_count got %0d want 3", task_cmd_q.size() - tb0); else passes++;
        for (int t = 0; t < 3 && tb0 + t < task_cmd_q.size(); t++) begin
            checks++; if ({task_cmd_q[tb0 + t], task_start_q[tb0 + t], task_end_q[tb0 + t]} !== {2'b10, exp_s[t], exp_e[t]})
                $display("FAIL rd_task[%0d] got %h %h %h want 2 %h %h", t, task_cmd_q[tb0 + t],
                         task_start_q[tb0 + t], task_end_q[tb0 + t], exp_s[t], exp_e[t]); else passes++;
        end
        checks++; if (rx_q.size() - rb0 !== 150) $display("FAIL rd_word_count got %0d want 150", rx_q.size() - rb0); else passes++;
        bad = 0;
        for (int i = 0; i < 150 && rb0 + i < rx_q.size(); i++)
            if (rx_q[rb0 + i] !== exp_rd(32'h100 + 32'(i))) bad++;
        checks++; if (bad !== 0) $display("FAIL rd_word_order got %0d bad words want 0", bad); else passes++;
        rd_ready_i = 1'b0;
    endtask

    task automatic test_fifo_backpressure();
        int tb0, rb0, cyc, bad;
        bit got; logic err;
        rb0 = rx_q.size();
        rd_ready_i = 1'b0;
        send_req(1'b0, 32'h300, 16'd64);
        wait_done(400, got, err, cyc);
        checks++; if (got !== 1'b1 || err !== 1'b0) $display("FAIL bp_prefill_done got done=%b err=%b want 1/0", got, err); else passes++;
        tb0 = task_cmd_q.size();
        send_req(1'b0, 32'h400, 16'd128);
        repeat (150) @(posedge clk_i);
        #1;
        checks++; if (task_cmd_q.size() - tb0 !== 1) $display("FAIL bp_first_chunk_only got %0d tasks want 1", task_cmd_q.size() - tb0); else passes++;
        checks++; if (req_ready_o !== 1'b0) $display("FAIL bp_still_busy got %b want 0", req_ready_o); else passes++;
        rd_ready_i = 1'b1;
        repeat (63) @(posedge clk_i);
        #1;
        rd_ready_i = 1'b0;
        repeat (20) @(posedge clk_i);
        #1;
        checks++; if (task_cmd_q.size() - tb0 !== 1) $display("FAIL bp_held_at_63 got %0d tasks want 1", task_cmd_q.size() - tb0); else passes++;
        rd_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rd_ready_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;
        checks++; if (task_cmd_q.size() - tb0 !== 2) $display("FAIL bp_released_at_64 got %0d tasks want 2", task_cmd_q.size() - tb0); else passes++;
        if (task_cmd_q.size() - tb0 == 2) begin
            checks++; if ({task_start_q[tb0 + 1], task_end_q[tb0 + 1]} !== {32'h440, 32'h47F})
                $display("FAIL bp_second_task got %h %h want 440 47f", task_start_q[tb0 + 1], task_end_q[tb0 + 1]); else passes++;
        end
        rd_ready_i = 1'b1;
        wait_done(1000, got, err, cyc);
        checks++; if (got !== 1'b1 || err !== 1'b0) $display("FAIL bp_done got done=%b err=%b want 1/0", got, err); else passes++;
        cyc = 0;
        while (rx_q.size() - rb0 < 192 && cyc < 300) begin @(posedge clk_i); cyc++; end
        repeat (3) @(posedge clk_i);
        checks++; if (rx_q.size() - rb0 !== 192) $display("FAIL bp_word_count got %0d want 192", rx_q.size() - rb0); else passes++;
        bad = 0;
        for (int i = 0; i < 192 && rb0 + i < rx_q.size(); i++)
            if (rx_q[rb0 + i] !== ((i < 64) ? exp_rd(32'h300 + 32'(i)) : exp_rd(32'h400 + 32'(i - 64)))) bad++;
        checks++; if (bad !== 0) $display("FAIL bp_word_order got %0d bad words want 0", bad); else passes++;
        rd_ready_i = 1'b0;
    endtask

    task automatic test_reject();
        int tb0 = task_cmd_q.size();
        int cyc; bit got; logic err;
        send_req(1'b1, 32'h50, 16'd0);
        wait_done(10, got, err, cyc);
        checks++; if (got !== 1'b1 || err !== 1'b0) $display("FAIL len0_done got done=%b err=%b want 1/0", got, err); else passes++;
        checks++; if (cyc > 3) $display("FAIL len0_latency got %0d cycles want <=3", cyc); else passes++;
        send_req(1'b0, 32'h0, 16'd1);
        wait_done(10, got, err, cyc);
        checks++; if (got !== 1'b1 || err !== 1'b1) $display("FAIL end0_reject got done=%b err=%b want 1/1", got, err); else passes++;
        send_req(1'b0, 32'hFFFF_FFFE, 16'd4);
        wait_done(10, got, err, cyc);
        checks++; if (got !== 1'b1 || err !== 1'b1) $display("FAIL ovf_reject got done=%b err=%b want 1/1", got, err); else passes++;
        checks++; if (task_cmd_q.size() - tb0 !== 0) $display("FAIL reject_no_command got %0d tasks want 0", task_cmd_q.size() - tb0); else passes++;
        rd_ready_i = 1'b1;
        send_req(1'b0, 32'hFFFF_FFFC, 16'd4);
        wait_done(100, got, err, cyc);
        checks++; if (got !== 1'b1 || err !== 1'b0) $display("FAIL top_of_space_done got done=%b err=%b want 1/0", got, err); else passes++;
        if (task_cmd_q.size() > tb0) begin
            checks++; if ({task_start_q[tb0], task_end_q[tb0]} !== {32'hFFFF_FFFC, 32'hFFFF_FFFF})
                $display("FAIL top_of_space_task got %h %h want fffffffc ffffffff", task_start_q[tb0], task_end_q[tb0]); else passes++;
        end
        repeat (5) @(posedge clk_i);
        rd_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid_transfer();
        int cyc; bit got; logic err;
        int tb0, wb0, base;
        rd_ready_i = 1'b0;
        send_req(1'b0, 32'h800, 16'd64);
        cyc = 0;
        while (rd_valid_o !== 1'b1 && cyc < 50) begin @(posedge clk_i); cyc++; end
        checks++; if (rd_valid_o !== 1'b1) $display("FAIL rst_run_reached got rd_valid=%b want 1", rd_valid_o); else passes++;
        repeat (5) @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        #1;
        checks++; if ({req_ready_o, rd_valid_o, done_o, mem_command_o} !== 5'b10000)
            $display("FAIL rst_async_outs got %b want 10000", {req_ready_o, rd_valid_o, done_o, mem_command_o}); else passes++;
        checks++; if ({mem_start_address_o, mem_end_address_o} !== 64'd0)
            $display("FAIL rst_async_addr got %h %h want 0 0", mem_start_address_o, mem_end_address_o); else passes++;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;
        checks++; if ({req_ready_o, rd_valid_o} !== 2'b10) $display("FAIL rst_idle_after got %b want 10", {req_ready_o, rd_valid_o}); else passes++;
        tb0 = task_cmd_q.size();
        wb0 = wr_words_q.size();
        base = wr_cnt;
        wr_valid_i = 1'b1;
        send_req(1'b1, 32'h20, 16'd3);
        wait_done(200, got, err, cyc);
        wr_valid_i = 1'b0;
        checks++; if (got !== 1'b1 || err !== 1'b0) $display("FAIL rst_recover_done got done=%b err=%b want 1/0", got, err); else passes++;
        checks++; if (task_cmd_q.size() - tb0 !== 1) $display("FAIL rst_recover_tasks got %0d want 1", task_cmd_q.size() - tb0); else passes++;
        if (task_cmd_q.size() > tb0) begin
            checks++; if ({task_cmd_q[tb0], task_start_q[tb0], task_end_q[tb0]} !== {2'b01, 32'h20, 32'h22})
                $display("FAIL rst_recover_task got %h %h %h want 1 20 22", task_cmd_q[tb0], task_start_q[tb0], task_end_q[tb0]); else passes++;
        end
        checks++; if (wr_words_q.size() - wb0 !== 3) $display("FAIL rst_recover_words got %0d want 3", wr_words_q.size() - wb0); else passes++;
        if (wr_words_q.size() - wb0 == 3) begin
            checks++; if (wr_words_q[wb0 + 2] !== 16'hC000 + 16'(base + 2))
                $display("FAIL rst_recover_last_word got %h want %h", wr_words_q[wb0 + 2], 16'hC000 + 16'(base + 2)); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_chunks();
        test_fifo_backpressure();
        test_reject();
        test_reset_mid_transfer();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
